// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request SRAM access sequencer with programmable strobe wait states
module mem_access_ctrl #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        be,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              req_err,
  output logic [ADDR_W-1:0] A,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  input  logic [DATA_W-1:0] mem_dq_in,
  output logic [DATA_W-1:0] mem_dq_out,
  output logic              mem_dq_oe
);
  localparam logic [2:0] IDLE = 3'd0, RD_WAIT = 3'd1, RD_DONE = 3'd2,
                         WR_SETUP = 3'd3, WR_PULSE = 3'd4, WR_HOLD = 3'd5;
  localparam logic [3:0] LOAD = 4'(WAIT_STATES - 1);
  logic [2:0] state, nxt;
  logic [3:0] cnt;
  logic       acc;
  assign busy = state != IDLE;
  assign acc = state == IDLE && (req_rd || req_wr);
  // write wins when both requests arrive together
  always_comb
    nxt = state == IDLE     ? (req_wr ? WR_SETUP : req_rd ? RD_WAIT : IDLE) :
          state == RD_WAIT  ? (cnt == 4'd0 ? RD_DONE : RD_WAIT) :
          state == WR_SETUP ? WR_PULSE :
          state == WR_PULSE ? (cnt == 4'd0 ? WR_HOLD : WR_PULSE) : IDLE;
  // strobes are registered decodes of the next state so they change cleanly on the edge
  always_ff @(posedge Clk)
    if (!Reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      A <= '0;
      CE <= 1'b1;
      UB <= 1'b1;
      LB <= 1'b1;
      OE <= 1'b1;
      WE <= 1'b1;
      mem_dq_oe <= 1'b0;
      mem_dq_out <= '0;
      rdata <= '0;
      done <= 1'b0;
      req_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (state == IDLE || state == WR_SETUP) ? LOAD : cnt == 4'd0 ? cnt : cnt - 4'd1;
      if (acc) A <= addr;
      UB <= nxt == IDLE ? 1'b1 : acc ? ~be[1] : UB;
      LB <= nxt == IDLE ? 1'b1 : acc ? ~be[0] : LB;
      if (state == IDLE && req_wr) mem_dq_out <= wdata;
      if (state == RD_WAIT && cnt == 4'd0) rdata <= mem_dq_in;
      CE <= !(nxt inside {RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD});
      OE <= nxt != RD_WAIT;
      WE <= nxt != WR_PULSE;
      mem_dq_oe <= nxt inside {WR_SETUP, WR_PULSE, WR_HOLD};
      done <= nxt == RD_DONE || nxt == WR_HOLD;
      req_err <= state == IDLE && req_rd && req_wr;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory access sequencer between the CPU datapath (MAR/MDR) and the external/test SRAM. It accepts one read or write request at a time and produces the active-low SRAM strobes (CE, UB, LB, OE, WE) with a programmable number of wait states. It drives or samples the SRAM data bus and returns read data with a one-cycle done pulse. The ISDU uses done instead of fixed memory-wait states.

Parameters:
WAIT_STATES, 2, cycles the OE (read) or WE (write) strobe is held active; legal range 1..15; 0 is illegal.
ADDR_W, 20, SRAM address width.
DATA_W, 16, SRAM data width.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Reset  input  1  synchronous, active-low reset.
req_rd  input  1  read request; sampled only in IDLE.
req_wr  input  1  write request; sampled only in IDLE.
addr  input  ADDR_W  request address (from MAR).
wdata  input  DATA_W  write data (from MDR).
be  input  2  byte enables, active-high; [1]=upper, [0]=lower.
rdata  output  DATA_W  registered read data (to MDR).
done  output  1  one-cycle pulse at access completion.
busy  output  1  high in every non-IDLE state.
req_err  output  1  one-cycle pulse when req_rd and req_wr are both sampled high in IDLE.
A  output  ADDR_W  SRAM address, registered.
CE, UB, LB, OE, WE  output  1 each  SRAM strobes, active-low, registered.
mem_dq_in  input  DATA_W  SRAM data bus, read side.
mem_dq_out  output  DATA_W  SRAM data bus, write side.
mem_dq_oe  output  1  high = controller drives the bus; the tristate lives in the top level.

Behaviour:
- Reset (Reset=0 at an edge), from any state including mid-access:
  - next state IDLE; A=0, CE=UB=LB=OE=WE=1, mem_dq_oe=0, mem_dq_out=0, rdata=0, done=0, busy=0, req_err=0, wait counter=0.
  - An interrupted access produces no done.
- Request acceptance:
  - Requests are only accepted in IDLE.
  - On acceptance, addr, be and wdata are latched. A, UB=~be[1], LB=~be[0] and CE=0 take effect in the next cycle.
  - Requests while busy=1 are ignored, not queued.
  - be=2'b00 is still a legal access: CE cycles, UB=LB=1.
  - req_rd and req_wr high together: the write wins and req_err pulses for one cycle.
- States: IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
- Read path:
  - IDLE -> RD_WAIT: OE=0, CE=0, counter loaded with WAIT_STATES-1.
  - RD_WAIT counts down. At count 0: rdata<=mem_dq_in, go to RD_DONE.
  - RD_DONE: OE=1, CE=1, done=1 for one cycle, then IDLE.
- Write path:
  - IDLE -> WR_SETUP: CE=0, WE=1, mem_dq_oe=1, mem_dq_out=wdata. Lasts one cycle.
  - WR_PULSE: WE=0 for WAIT_STATES cycles.
  - WR_HOLD: WE=1, mem_dq_oe still 1 (data hold), done=1. Then IDLE with CE=1, mem_dq_oe=0.
- Latency (request sampled in cycle 0): read done in cycle WAIT_STATES+1; write done in cycle WAIT_STATES+2.
- Back-to-back accesses: a request can be accepted in the first IDLE cycle after done. No zero-idle chaining.
- Bus safety invariants:
  - mem_dq_oe=1 only in WR_SETUP, WR_PULSE and WR_HOLD.
  - OE and WE are never both 0 in the same cycle.
  - WE=0 only while A and mem_dq_out are stable.
- rdata holds its value until the next completed read.
- busy = (state != IDLE). Upstream uses busy to block new requests.

Test Plan:
- Reset: hold Reset=0 for 3 cycles with random inputs -> all strobes 1, mem_dq_oe=0, rdata=0, busy=0, done=0.
- Read, WAIT_STATES=2: req_rd with addr=0x00123, be=2'b11, mem_dq_in=0xBEEF -> OE=0 in cycles 1-2; done in cycle 3; rdata=0xBEEF; A=0x00123 throughout; WE stays 1.
- Write, WAIT_STATES=2: req_wr with addr=0x00040, wdata=0x1234, be=2'b01 -> UB=1, LB=0; WE=0 exactly in cycles 2-3; mem_dq_out=0x1234 with mem_dq_oe=1 in cycles 1-4; done in cycle 4.
- Conflict and ignore: req_rd=req_wr=1 -> write sequence runs and req_err pulses once. A req_rd pulsed during WR_PULSE -> ignored, no second done.
- Reset mid-access: Reset=0 during WR_PULSE -> next cycle WE=1, CE=1, mem_dq_oe=0, no done. A following read completes normally.
- Boundaries: WAIT_STATES=1 read gives done in cycle 2; WAIT_STATES=15 write gives done in cycle 17. Back-to-back read→write→read with no gaps beyond the required IDLE cycle returns correct data. Assertion: OE and WE are never both low.
